// File: rtl/gap_requant_unit_pkg.sv
// gap_requant_unit_pkg: shared sizes, FSM state encoding and the ReLU helper for the GAP/requant stage
package gap_requant_unit_pkg;
    localparam int CH    = 32;
    localparam int HW    = 16;
    localparam int SHIFT = 4;
    localparam int IN_W  = 16;
    // Sum of HW non-negative IN_W-bit samples fits in IN_W+SHIFT unsigned bits.
    localparam int ACC_W = IN_W + SHIFT;
    localparam int CH_W  = $clog2(CH);
    localparam int POS_W = $clog2(HW);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(HW - 1);
    typedef enum logic {S_ACC = 1'b0, S_DRAIN = 1'b1} state_t;
    function automatic logic [ACC_W-1:0] relu(input logic signed [IN_W-1:0] x);
        return x[IN_W-1] ? '0 : {{SHIFT{1'b0}}, x};
    endfunction
endpackage

// File: rtl/gap_requant_unit_if.sv
// gap_requant_unit_if: feature-stream input and pooled-byte output of the GAP/requant stage
//   in_data/in_valid/in_ready : signed feature samples, valid/ready handshake
//   out_data/out_valid        : pooled unsigned bytes, no backpressure
//   frame_done                : pulse with the last byte of a frame
interface gap_requant_unit_if;
    import gap_requant_unit_pkg::*;
    logic signed [IN_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   frame_done;
    modport master (output in_data, in_valid, input in_ready, out_data, out_valid, frame_done);
    modport slave  (input in_data, in_valid, output in_ready, out_data, out_valid, frame_done);
endinterface

// File: rtl/gap_requant_unit_requant_round_sat.sv
// requant_round_sat: half-up rounding divide by 2**SHIFT with unsigned 8-bit saturation
//   acc : unsigned channel sum (ACC_W bits)
//   q   : rounded average, clamped to 255
module requant_round_sat
    import gap_requant_unit_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    output logic [7:0]       q
);
    // One extra bit so adding the rounding constant can never wrap.
    logic [ACC_W:0] avg;
    always_comb begin
        avg = ({1'b0, acc} + (ACC_W+1)'(1 << (SHIFT - 1))) >> SHIFT;
        q   = |avg[ACC_W:8] ? 8'hff : avg[7:0];
    end
endmodule

// File: rtl/gap_requant_unit.sv
// gap_requant_unit: ReLU + global average pool + requantise to unsigned bytes
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of gap_requant_unit_if (sample stream in, byte burst out)
module gap_requant_unit
    import gap_requant_unit_pkg::*;
(
    input logic              clk,
    input logic              rst,
    gap_requant_unit_if.slave bus
);
    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
    logic [POS_W-1:0]  pos_cnt_q, pos_cnt_d;
    logic [ACC_W-1:0]  acc_q [CH];
    logic [ACC_W-1:0]  acc_d [CH];
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              in_ready, accept, last_ch;
    logic [ACC_W-1:0]  acc_sel;
    logic [7:0]        rq;

    assign acc_sel = acc_q[ch_cnt_q];

    requant_round_sat u_rs (.acc(acc_sel), .q(rq));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_ACC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_ACC)
            state_d = (accept && last_ch && pos_cnt_q == POS_LAST) ? S_DRAIN : S_ACC;
        else
            state_d = last_ch ? S_ACC : S_DRAIN;
    end

    always_comb begin
        in_ready       = (state_q == S_ACC);
        bus.in_ready   = in_ready;
        bus.out_data   = out_data_q;
        bus.out_valid  = out_valid_q;
        bus.frame_done = frame_done_q;
    end

    always_comb begin
        accept       = bus.in_valid && in_ready;
        last_ch      = (ch_cnt_q == CH_LAST);
        acc_d        = acc_q;
        ch_cnt_d     = ch_cnt_q;
        pos_cnt_d    = pos_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (state_q == S_ACC) begin
            if (accept) begin
                acc_d[ch_cnt_q] = acc_q[ch_cnt_q] + relu(bus.in_data);
                ch_cnt_d        = last_ch ? '0 : ch_cnt_q + 1'b1;
                if (last_ch) pos_cnt_d = (pos_cnt_q == POS_LAST) ? '0 : pos_cnt_q + 1'b1;
            end
        end else begin
            out_data_d   = rq;
            out_valid_d  = 1'b1;
            frame_done_d = last_ch;
            ch_cnt_d     = last_ch ? '0 : ch_cnt_q + 1'b1;
            // Clear the bank on the final byte so the next frame starts from zero.
            if (last_ch) for (int i = 0; i < CH; i++) acc_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt_q     <= '0;
            pos_cnt_q    <= '0;
            acc_q        <= '{default: '0};
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            ch_cnt_q     <= ch_cnt_d;
            pos_cnt_q    <= pos_cnt_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_gap_requant_unit.sv
// tb_gap_requant_unit: scoreboard bench for gap_requant_unit with directed frames
module tb_gap_requant_unit;
    import gap_requant_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];

    gap_requant_unit_if bus ();
    gap_requant_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic logic signed [15:0] sval(input int mode, input int p, input int c);
        case (mode)
            0: return 16'sd10;
            1: return 16'(4 * c);
            2: return 16'sd300;
            3: return -16'sd5;
            4: return (c == 0) ? ((p < 8) ? 16'sd1 : 16'sd2) : 16'sd0;
            5: return (c == 0) ? ((p == 0) ? 16'sd8 : 16'sd1) : ((c == 1 && p == 0) ? 16'sd7 : 16'sd0);
            6: return (c == 0 && p == 0) ? 16'sd8 : 16'sd0;
            default: return 16'sd7;
        endcase
    endfunction

    function automatic logic [7:0] expv(input int mode, input int c);
        case (mode)
            0: return 8'd10;
            1: return 8'(4 * c);
            2: return 8'd255;
            3: return 8'd0;
            4: return (c == 0) ? 8'd2 : 8'd0;
            5: return (c == 0) ? 8'd1 : 8'd0;
            6: return (c == 0) ? 8'd1 : 8'd0;
            default: return 8'd7;
        endcase
    endfunction

    task automatic send(input logic signed [15:0] v);
        int t = 0;
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic frame(input int mode, input bit gaps, input bit hold);
        int t = 0;
        for (int c = 0; c < CH; c++) exp_q.push_back({(c == CH - 1), expv(mode, c)});
        for (int p = 0; p < HW; p++)
            for (int c = 0; c < CH; c++) begin
                if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send(sval(mode, p, c));
            end
        if (hold) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'sd1000;
            chk("in_ready_after_last", bus.in_ready, 0);
            while (!bus.in_ready && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            bus.in_valid = 1'b0;
            chk("hold_ready_return", bus.in_ready, 1);
        end
    endtask

    task automatic wait_empty();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int burst = 0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst) burst = 0;
            else if (bus.out_valid) begin
                if (exp_q.size() == 0) chk("stray_out_valid", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e[7:0]);
                    chk("frame_done", bus.frame_done, e[8]);
                    chk("in_ready_in_drain", bus.in_ready, e[8]);
                end
                burst = bus.frame_done ? 0 : burst + 1;
            end else begin
                chk("idle_frame_done", bus.frame_done, 0);
                if (burst != 0) begin
                    chk("burst_gap", burst, 0);
                    burst = 0;
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        frame(0, 0, 0);
        frame(1, 1, 0);
        frame(2, 0, 1);
        frame(3, 1, 0);
        frame(4, 0, 0);
        frame(5, 0, 0);
        frame(6, 1, 1);
        frame(0, 1, 1);
        wait_empty();
        for (int i = 0; i < 200; i++) send(sval(0, i / CH, i % CH));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        frame(7, 0, 0);
        wait_empty();
        repeat (5) @(posedge clk);
        #1;
        chk("end_out_valid", bus.out_valid, 0);
        chk("end_out_data_hold", bus.out_data, 7);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
